// File: rtl/preproc_mc.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : preproc_mc                                                   |
// | Description : Multi-channel DFT pre-processing front end. Strips a         |
// |               programmable cyclic prefix, keeps trans_len payload samples  |
// |               per block, buffers them in a shared FIFO and drives them out |
// |               under valid/ready backpressure with a sticky overflow flag.  |
// | Options     : PREPROC_MC_GAIN_EN enables saturating left-shift gain.       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module preproc_mc #(
  parameter int NUM_CH = 2,
  parameter int DW     = 16,
  parameter int LEN_W  = 12,
  parameter int AW     = 11
) (
  input  logic                 clk_sys,
  input  logic                 rst_sys,
  input  logic                 block_sync_i,
  input  logic                 data_val_i,
  input  logic [NUM_CH*DW-1:0] data_re_i,
  input  logic [NUM_CH*DW-1:0] data_im_i,
  input  logic [LEN_W-1:0]     trans_len_i,
  input  logic [LEN_W-1:0]     cp_len_i,
  input  logic [2:0]           gain_shift_i,
  input  logic                 ovf_clr_i,
  input  logic                 ready_i,
  output logic                 block_sync_o,
  output logic                 data_val_o,
  output logic [NUM_CH*DW-1:0] data_re_o,
  output logic [NUM_CH*DW-1:0] data_im_o,
  output logic                 ovf_o,
  output logic                 busy_o
);

  localparam int c_cw    = NUM_CH * DW;
  localparam int c_ew    = 2 * c_cw + 1;
  localparam int c_depth = 1 << AW;
  localparam logic [LEN_W-1:0] c_one = LEN_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SKIP    = 2'd1,
    ST_CAPTURE = 2'd2
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [LEN_W-1:0] r_cnt, w_cnt_nxt;
  logic [LEN_W-1:0] r_trans_len, r_cp_len;
  logic             w_sync, w_wr_smp, w_wr_tag;

  logic             r_st_val, r_st_tag;
  logic [c_cw-1:0]  r_st_re, r_st_im, w_proc_re, w_proc_im;

  logic [AW:0]      r_wr_ptr, r_rd_ptr;
  logic [c_ew-1:0]  r_mem [c_depth];
  logic             w_empty, w_full, w_rd, w_wr, w_drop;

  logic             r_out_val, r_out_tag, r_ovf;
  logic [c_cw-1:0]  r_out_re, r_out_im;

  assign w_sync = data_val_i & block_sync_i;

  // Block lengths are captured on the sync sample so mid-block changes have no effect
  always_ff @(posedge clk_sys) begin
    if (rst_sys) begin
      r_trans_len <= '0;
      r_cp_len    <= '0;
    end else if (w_sync) begin
      r_trans_len <= trans_len_i;
      r_cp_len    <= cp_len_i;
    end
  end

`ifdef PREPROC_MC_GAIN_EN
  localparam logic signed [DW+7:0] c_sat_max = {9'b0, {(DW-1){1'b1}}};
  localparam logic signed [DW+7:0] c_sat_min = -c_sat_max;

  logic [2:0] r_gain_shift, w_shift;

  // The sync sample may itself be payload 0, so it uses the live shift value
  assign w_shift = w_sync ? gain_shift_i : r_gain_shift;

  // Gain shift is latched together with the block lengths
  always_ff @(posedge clk_sys) begin
    if (rst_sys)     r_gain_shift <= '0;
    else if (w_sync) r_gain_shift <= gain_shift_i;
  end

  // Symmetric saturation: the most-negative code is never produced
  function automatic logic [DW-1:0] sat_shift(input logic [DW-1:0] x, input logic [2:0] sh);
    logic signed [DW+7:0] v;
    v = $signed({{8{x[DW-1]}}, x}) <<< sh;
    if (v > c_sat_max)      return c_sat_max[DW-1:0];
    else if (v < c_sat_min) return c_sat_min[DW-1:0];
    else                    return v[DW-1:0];
  endfunction
`else
  logic w_unused_gain;
  assign w_unused_gain = ^gain_shift_i;
`endif

  generate
    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
`ifdef PREPROC_MC_GAIN_EN
      assign w_proc_re[g*DW +: DW] = sat_shift(data_re_i[g*DW +: DW], w_shift);
      assign w_proc_im[g*DW +: DW] = sat_shift(data_im_i[g*DW +: DW], w_shift);
`else
      assign w_proc_re[g*DW +: DW] = data_re_i[g*DW +: DW];
      assign w_proc_im[g*DW +: DW] = data_im_i[g*DW +: DW];
`endif
    end
  endgenerate

  // FSM state and position counter register
  always_ff @(posedge clk_sys) begin
    if (rst_sys) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next state: a sync from any state restarts the block using the live lengths
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_wr_smp    = 1'b0;
    w_wr_tag    = 1'b0;
    if (w_sync) begin
      w_cnt_nxt = '0;
      if (trans_len_i == '0) begin
        w_state_nxt = ST_IDLE;
      end else if (cp_len_i == '0) begin
        w_wr_smp = 1'b1;
        w_wr_tag = 1'b1;
        if (trans_len_i == c_one) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_CAPTURE;
          w_cnt_nxt   = c_one;
        end
      end else if (cp_len_i == c_one) begin
        w_state_nxt = ST_CAPTURE;
      end else begin
        w_state_nxt = ST_SKIP;
        w_cnt_nxt   = c_one;
      end
    end else if (data_val_i) begin
      case (r_state)
        ST_SKIP: begin
          if (r_cnt == r_cp_len - c_one) begin
            w_state_nxt = ST_CAPTURE;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt + c_one;
          end
        end
        ST_CAPTURE: begin
          w_wr_smp = 1'b1;
          w_wr_tag = (r_cnt == '0);
          if (r_cnt == r_trans_len - c_one) begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt + c_one;
          end
        end
        default: ;
      endcase
    end
  end

  // Gain/saturation pipeline stage ahead of the FIFO write
  always_ff @(posedge clk_sys) begin
    if (rst_sys) begin
      r_st_val <= 1'b0;
      r_st_tag <= 1'b0;
      r_st_re  <= '0;
      r_st_im  <= '0;
    end else begin
      r_st_val <= w_wr_smp;
      r_st_tag <= w_wr_tag;
      r_st_re  <= w_proc_re;
      r_st_im  <= w_proc_im;
    end
  end

  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_rd    = (!r_out_val || ready_i) && !w_empty;
  // A read in the same cycle frees a slot, so a write on full is still accepted then
  assign w_wr    = r_st_val && (!w_full || w_rd);
  assign w_drop  = r_st_val && w_full && !w_rd;

  // FIFO storage; contents need no reset because the pointers define validity
  always_ff @(posedge clk_sys) begin
    if (w_wr) r_mem[r_wr_ptr[AW-1:0]] <= {r_st_tag, r_st_re, r_st_im};
  end

  // FIFO pointers, flushed by reset
  always_ff @(posedge clk_sys) begin
    if (rst_sys) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // Output register: reloads when free or being consumed, otherwise holds
  always_ff @(posedge clk_sys) begin
    if (rst_sys) begin
      r_out_val <= 1'b0;
      r_out_tag <= 1'b0;
      r_out_re  <= '0;
      r_out_im  <= '0;
    end else if (w_rd) begin
      r_out_val <= 1'b1;
      {r_out_tag, r_out_re, r_out_im} <= r_mem[r_rd_ptr[AW-1:0]];
    end else if (ready_i) begin
      r_out_val <= 1'b0;
    end
  end

  // Sticky overflow; a new drop wins over a clear in the same cycle
  always_ff @(posedge clk_sys) begin
    if (rst_sys)        r_ovf <= 1'b0;
    else if (w_drop)    r_ovf <= 1'b1;
    else if (ovf_clr_i) r_ovf <= 1'b0;
  end

  assign data_val_o   = r_out_val;
  assign block_sync_o = r_out_val & r_out_tag;
  assign data_re_o    = r_out_re;
  assign data_im_o    = r_out_im;
  assign ovf_o        = r_ovf;
  assign busy_o       = (r_state != ST_IDLE) || !w_empty;

endmodule
`default_nettype wire

// File: tb/tb_preproc_mc.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_preproc_mc                                                |
// | Description : Randomized self-checking bench for preproc_mc against a      |
// |               block-level reference model (sample position, queue FIFO).   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_preproc_mc;

  localparam int NUM_CH = 2;
  localparam int DW     = 16;
  localparam int LEN_W  = 12;
  localparam int AW     = 3;
  localparam int DEPTH  = 1 << AW;
  localparam int CW     = NUM_CH * DW;

  logic              clk_sys = 1'b0;
  logic              rst_sys;
  logic              block_sync_i, data_val_i, ovf_clr_i, ready_i;
  logic [CW-1:0]     data_re_i, data_im_i;
  logic [LEN_W-1:0]  trans_len_i, cp_len_i;
  logic [2:0]        gain_shift_i;
  logic              block_sync_o, data_val_o, ovf_o, busy_o;
  logic [CW-1:0]     data_re_o, data_im_o;

  int n_checks = 0;
  int n_fail   = 0;

  preproc_mc #(.NUM_CH(NUM_CH), .DW(DW), .LEN_W(LEN_W), .AW(AW)) dut (
    .clk_sys(clk_sys), .rst_sys(rst_sys),
    .block_sync_i(block_sync_i), .data_val_i(data_val_i),
    .data_re_i(data_re_i), .data_im_i(data_im_i),
    .trans_len_i(trans_len_i), .cp_len_i(cp_len_i),
    .gain_shift_i(gain_shift_i), .ovf_clr_i(ovf_clr_i), .ready_i(ready_i),
    .block_sync_o(block_sync_o), .data_val_o(data_val_o),
    .data_re_o(data_re_o), .data_im_o(data_im_o),
    .ovf_o(ovf_o), .busy_o(busy_o)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h expected=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic          tag;
    logic [CW-1:0] re;
    logic [CW-1:0] im;
  } smp_t;

  smp_t q[$];
  smp_t m_out, m_st;
  bit   m_out_val, m_st_val, m_ovf, m_act, m_init;
  int   m_pos, m_cp, m_len, m_sh;

  function automatic logic [CW-1:0] proc(input logic [CW-1:0] x, input int sh);
    logic [CW-1:0] r;
    int v;
    r = x;
`ifdef PREPROC_MC_GAIN_EN
    for (int c = 0; c < NUM_CH; c++) begin
      v = int'($signed(x[c*DW +: DW])) * (1 << sh);
      if (v > 32767)  v = 32767;
      if (v < -32767) v = -32767;
      r[c*DW +: DW] = v[DW-1:0];
    end
`else
    v = sh;
`endif
    return r;
  endfunction

  always @(posedge clk_sys) begin
    bit rd, full, set;
    if (rst_sys) begin
      q.delete();
      m_out_val = 0; m_st_val = 0; m_ovf = 0; m_act = 0; m_pos = 0; m_init = 1;
    end else if (m_init) begin
      rd   = (!m_out_val || ready_i) && q.size() > 0;
      full = (q.size() == DEPTH);
      set  = 0;
      if (rd) begin
        m_out = q.pop_front();
        m_out_val = 1;
      end else if (ready_i) begin
        m_out_val = 0;
      end
      if (m_st_val) begin
        if (!full || rd) q.push_back(m_st);
        else set = 1;
      end
      if (set) m_ovf = 1;
      else if (ovf_clr_i) m_ovf = 0;
      m_st_val = 0;
      if (data_val_i) begin
        if (block_sync_i) begin
          m_cp = int'(cp_len_i); m_len = int'(trans_len_i); m_sh = int'(gain_shift_i);
          m_pos = 0; m_act = (m_len > 0);
        end
        if (m_act) begin
          if (m_pos >= m_cp) begin
            m_st_val = 1;
            m_st = '{tag: (m_pos == m_cp), re: proc(data_re_i, m_sh), im: proc(data_im_i, m_sh)};
          end
          m_pos++;
          if (m_pos >= m_cp + m_len) m_act = 0;
        end
      end
    end
  end

  // Continuous comparison of the DUT against the model on the falling edge
  always @(negedge clk_sys) begin
    if (m_init && !rst_sys) begin
      chk("val",  data_val_o, m_out_val);
      chk("ovf",  ovf_o, m_ovf);
      chk("busy", busy_o, m_act || q.size() > 0);
      if (m_out_val) begin
        chk("sync", block_sync_o, m_out.tag);
        chk("re",   data_re_o, m_out.re);
        chk("im",   data_im_o, m_out.im);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc_d(input bit v, input bit s, input logic [CW-1:0] re, input logic [CW-1:0] im);
    data_val_i = v; block_sync_i = s; data_re_i = re; data_im_i = im;
    @(negedge clk_sys);
  endtask

  task automatic cyc(input bit v, input bit s);
    cyc_d(v, s, CW'($urandom), CW'($urandom));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0);
  endtask

  task automatic set_len(input int cp, input int len, input int sh);
    cp_len_i = LEN_W'(cp); trans_len_i = LEN_W'(len); gain_shift_i = 3'(sh);
  endtask

  logic [CW-1:0] ramp;

  initial begin
    rst_sys = 1; data_val_i = 0; block_sync_i = 0; ovf_clr_i = 0; ready_i = 1;
    data_re_i = '0; data_im_i = '0; set_len(0, 0, 0);
    repeat (3) @(negedge clk_sys);
    chk("rst_val",  data_val_o, 1'b0);
    chk("rst_sync", block_sync_o, 1'b0);
    chk("rst_re",   data_re_o, '0);
    chk("rst_im",   data_im_o, '0);
    chk("rst_ovf",  ovf_o, 1'b0);
    chk("rst_busy", busy_o, 1'b0);
    rst_sys = 0;
    idle(2);

    // T1: cp=4 len=8 ramp, first output is sample 4 with sync two edges after its input edge
    set_len(4, 8, 0);
    for (int i = 0; i < 12; i++) begin
      ramp = {16'(i), 16'(i)};
      cyc_d(1'b1, i == 0, ramp, ~ramp);
      if (i == 6) begin
        chk("t1_lat_val",  data_val_o, 1'b1);
        chk("t1_lat_sync", block_sync_o, 1'b1);
        chk("t1_lat_re",   data_re_o, {16'd4, 16'd4});
      end
    end
    idle(6);

    // T2: cp=0, len=3, then a valid sample without sync must be ignored
    set_len(0, 3, 0);
    cyc(1, 1); cyc(1, 0); cyc(1, 0); cyc(1, 0); cyc(1, 0);
    idle(6);
    chk("t2_busy", busy_o, 1'b0);

    // T3: overflow with ready held low
    ready_i = 0;
    set_len(0, 12, 0);
    cyc(1, 1);
    for (int i = 1; i < 12; i++) cyc(1, 0);
    idle(8);
    chk("t3_ovf_set", ovf_o, 1'b1);
    ovf_clr_i = 1; idle(1); ovf_clr_i = 0;
    chk("t3_ovf_clr", ovf_o, 1'b0);
    ready_i = 1;
    idle(12);

    // T4: sync re-asserted at payload 5 of an 8-sample block
    set_len(0, 8, 0);
    cyc(1, 1);
    for (int i = 1; i < 5; i++) cyc(1, 0);
    set_len(1, 4, 0);
    cyc(1, 1);
    for (int i = 0; i < 5; i++) cyc(1, 0);
    idle(8);

`ifdef PREPROC_MC_GAIN_EN
    // T5: saturating gain
    set_len(0, 3, 3);
    cyc_d(1, 1, {16'sd5000, 16'sd5000}, {16'sd5000, 16'sd5000});
    cyc_d(1, 0, {-16'sd5000, -16'sd5000}, {-16'sd5000, -16'sd5000});
    cyc_d(1, 0, {16'h8000, 16'h8000}, {16'h8000, 16'h8000});
    chk("t5_pos", data_re_o, {16'sd32767, 16'sd32767});
    cyc(0, 0);
    chk("t5_neg", data_re_o, {-16'sd32767, -16'sd32767});
    cyc(0, 0);
    chk("t5_min", data_re_o, {-16'sd32767, -16'sd32767});
    idle(4);
`endif

    // Randomized blocks: mixed gaps, backpressure, aborts, mid-block config changes
    for (int b = 0; b < 40; b++) begin
      int n;
      set_len($urandom_range(0, 4), $urandom_range(0, 10), $urandom_range(0, 7));
      n = $urandom_range(1, 16);
      ready_i = ($urandom_range(0, 9) < 7);
      cyc(1, 1);
      for (int i = 0; i < n; i++) begin
        ready_i   = ($urandom_range(0, 9) < 7);
        ovf_clr_i = ($urandom_range(0, 19) == 0);
        if ($urandom_range(0, 7) == 0) set_len($urandom_range(0, 4), $urandom_range(0, 10), $urandom_range(0, 7));
        cyc($urandom_range(0, 3) != 0, $urandom_range(0, 24) == 0);
      end
      ovf_clr_i = 0;
    end
    ready_i = 1;
    idle(14);

    // T6: reset in mid-capture with several entries buffered
    ready_i = 0;
    set_len(0, 10, 0);
    cyc(1, 1);
    for (int i = 1; i < 7; i++) cyc(1, 0);
    idle(1);
    rst_sys = 1;
    cyc(1, 0);
    rst_sys = 0;
    chk("t6_val",  data_val_o, 1'b0);
    chk("t6_busy", busy_o, 1'b0);
    ready_i = 1;
    cyc(1, 0); cyc(1, 0);
    idle(6);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
